// File: rtl/fabric_tb_pkg.sv
// ============================================================================
//  Module      : fabric_tb_pkg
//  Description : Shared types and helpers for the fabric stimulus driver.
//                - stim_state_t : sequencing states of the driver FSM
//                - VEC_STIM_LSB / vec_exp_lsb() : slicing of a vector ROM
//                  word into {expected, stimulus}
//                - addr_width() : address width of a table, at least 1 bit
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fabric_tb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD1 = 3'd1,
      ST_LOAD2 = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } stim_state_t;

   // Stimulus occupies the low field of a vector ROM word.
   localparam int VEC_STIM_LSB = 0;

   // The expected-output field sits directly above the stimulus field.
   function automatic int vec_exp_lsb(input int in_width);
      return in_width;
   endfunction

   // Address width for a table of the given depth; never narrower than 1.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : fabric_tb_pkg

`default_nettype wire

// File: rtl/stim_delay_line.sv
// ============================================================================
//  Module      : stim_delay_line
//  Description : Launch register followed by DEPTH further register stages.
//                With DEPTH=0 the word leaves on the same cycle as the other
//                registered outputs of the driver; each extra stage adds one
//                cycle of latency.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset, clears every stage
//                d_i  - word to delay, {valid, expected}
//                q_o  - delayed word
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stim_delay_line #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i <= DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH];

endmodule : stim_delay_line

`default_nettype wire

// File: rtl/fabric_stim_driver.sv
// ============================================================================
//  Module      : fabric_stim_driver
//  Description : Reads a config bitstream and a vector table from two
//                synchronous-read ROMs, shifts the bitstream into the fabric
//                config chain twice, then drives the data vectors. Produces
//                the expected chain output, the expected data output (delayed
//                by DUT_LATENCY) and a sticky completion flag.
//  Ports       : clk, rst            - clock, async active-high reset
//                start               - level, sampled only in IDLE
//                cfg_addr/cfg_rdata  - bitstream ROM (1-cycle read latency)
//                vec_addr/vec_rdata  - vector ROM {expected, stimulus}
//                config_in/config_en - serial config chain drive
//                expected_config_out - predicted chain output
//                datain              - DUT stimulus
//                expected_dataout    - predicted DUT output, with exp_valid
//                busy, sim_done      - status
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fabric_stim_driver
   import fabric_tb_pkg::*;
#(
   parameter int DATA_IN_WIRE_WIDTH  = 8,
   parameter int DATA_OUT_WIRE_WIDTH = 8,
   parameter int CONFIG_WIDTH        = 64,
   parameter int NUM_VECTORS         = 16,
   parameter int DUT_LATENCY         = 1
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             start,
   output logic [addr_width(CONFIG_WIDTH)-1:0]              cfg_addr,
   input  logic                                             cfg_rdata,
   output logic [addr_width(NUM_VECTORS)-1:0]               vec_addr,
   input  logic [DATA_IN_WIRE_WIDTH+DATA_OUT_WIRE_WIDTH-1:0] vec_rdata,
   output logic                                             config_in,
   output logic                                             config_en,
   output logic                                             expected_config_out,
   output logic [DATA_IN_WIRE_WIDTH-1:0]                    datain,
   output logic [DATA_OUT_WIRE_WIDTH-1:0]                   expected_dataout,
   output logic                                             exp_valid,
   output logic                                             busy,
   output logic                                             sim_done
);

   localparam int CFG_AW  = addr_width(CONFIG_WIDTH);
   localparam int VEC_AW  = addr_width(NUM_VECTORS);
   localparam int EXP_LSB = vec_exp_lsb(DATA_IN_WIRE_WIDTH);
   localparam int CNT_W   = addr_width(DUT_LATENCY + 2);

   localparam logic [CFG_AW-1:0] CFG_LAST   = CFG_AW'(CONFIG_WIDTH - 1);
   localparam logic [VEC_AW-1:0] VEC_LAST   = VEC_AW'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0]  TAIL_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);

   // ------------------------------------------------------------------------
   // Sequencer: the state register tracks the address-issue side. Data lags
   // the address by two cycles (ROM read + output register), so RUN stays
   // two cycles past the last vector address to let the final vector reach
   // datain; DRAIN then covers only the DUT_LATENCY delay line.
   // ------------------------------------------------------------------------
   stim_state_t        state_q,    state_d;
   logic [CFG_AW-1:0]  cfg_addr_q, cfg_addr_d;
   logic [VEC_AW-1:0]  vec_addr_q, vec_addr_d;
   logic               vec_done_q, vec_done_d;   // all vector addresses issued
   logic [CNT_W-1:0]   cnt_q,      cnt_d;        // RUN tail / DRAIN counter

   always_comb begin
      state_d    = state_q;
      cfg_addr_d = cfg_addr_q;
      vec_addr_d = vec_addr_q;
      vec_done_d = vec_done_q;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD1;
            end
         end

         ST_LOAD1, ST_LOAD2: begin
            if (cfg_addr_q == CFG_LAST) begin
               cfg_addr_d = '0;
               state_d    = (state_q == ST_LOAD1) ? ST_LOAD2 : ST_RUN;
            end else begin
               cfg_addr_d = cfg_addr_q + CFG_AW'(1);
            end
         end

         ST_RUN: begin
            if (!vec_done_q) begin
               if (vec_addr_q == VEC_LAST) begin
                  vec_addr_d = '0;
                  vec_done_d = 1'b1;
               end else begin
                  vec_addr_d = vec_addr_q + VEC_AW'(1);
               end
            end else if (cnt_q == TAIL_LAST) begin
               cnt_d      = '0;
               vec_done_d = 1'b0;
               state_d    = (DUT_LATENCY > 0) ? ST_DRAIN : ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_DONE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output pipeline. Stage s1 tags the cycle in which ROM data for an
   // address issued in the previous cycle is on cfg_rdata/vec_rdata; the
   // outputs are registered from that stage.
   // ------------------------------------------------------------------------
   logic w_cfg_issue;
   logic w_vec_issue;

   assign w_cfg_issue = (state_q == ST_LOAD1) || (state_q == ST_LOAD2);
   assign w_vec_issue = (state_q == ST_RUN) && !vec_done_q;

   logic                          s1_cfg_q;
   logic                          s1_ld2_q;
   logic                          s1_vec_q;
   logic                          config_in_q;
   logic                          config_en_q;
   logic                          exp_cfg_q;
   logic [DATA_IN_WIRE_WIDTH-1:0] datain_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cfg_addr_q  <= '0;
         vec_addr_q  <= '0;
         vec_done_q  <= 1'b0;
         cnt_q       <= '0;
         s1_cfg_q    <= 1'b0;
         s1_ld2_q    <= 1'b0;
         s1_vec_q    <= 1'b0;
         config_in_q <= 1'b0;
         config_en_q <= 1'b0;
         exp_cfg_q   <= 1'b0;
         datain_q    <= '0;
      end else begin
         state_q     <= state_d;
         cfg_addr_q  <= cfg_addr_d;
         vec_addr_q  <= vec_addr_d;
         vec_done_q  <= vec_done_d;
         cnt_q       <= cnt_d;
         s1_cfg_q    <= w_cfg_issue;
         s1_ld2_q    <= (state_q == ST_LOAD2);
         s1_vec_q    <= w_vec_issue;
         config_en_q <= s1_cfg_q;
         config_in_q <= s1_cfg_q & cfg_rdata;
         // The chain powers up at zero, so nothing but zeros come out during
         // the first pass; on the second pass each bit leaving the chain is
         // the bit that entered CONFIG_WIDTH shifts earlier.
         exp_cfg_q   <= s1_ld2_q & cfg_rdata;
         datain_q    <= s1_vec_q ? vec_rdata[VEC_STIM_LSB +: DATA_IN_WIRE_WIDTH] : '0;
      end
   end

   // Expected field is zeroed when not valid so expected_dataout reads 0
   // whenever exp_valid is low.
   logic [DATA_OUT_WIRE_WIDTH:0] w_exp_in;
   logic [DATA_OUT_WIRE_WIDTH:0] w_exp_out;

   assign w_exp_in = {s1_vec_q,
                      s1_vec_q ? vec_rdata[EXP_LSB +: DATA_OUT_WIRE_WIDTH]
                               : {DATA_OUT_WIRE_WIDTH{1'b0}}};

   stim_delay_line #(
      .WIDTH (DATA_OUT_WIRE_WIDTH + 1),
      .DEPTH (DUT_LATENCY)
   ) u_exp_delay (
      .clk (clk),
      .rst (rst),
      .d_i (w_exp_in),
      .q_o (w_exp_out)
   );

   assign cfg_addr            = cfg_addr_q;
   assign vec_addr            = vec_addr_q;
   assign config_in           = config_in_q;
   assign config_en           = config_en_q;
   assign expected_config_out = exp_cfg_q;
   assign datain              = datain_q;
   assign exp_valid           = w_exp_out[DATA_OUT_WIRE_WIDTH];
   assign expected_dataout    = w_exp_out[DATA_OUT_WIRE_WIDTH-1:0];
   assign busy                = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign sim_done            = (state_q == ST_DONE);

endmodule : fabric_stim_driver

`default_nettype wire
